// File: rtl/fpmul_result_fifo.sv
// Result FIFO for the FP multiplier: special-value fixup on entry, sticky exception flags.
// Optional saturating exception counters are built when FPMUL_FLAG_COUNT_EN is defined.
module fpmul_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_y,
  input  logic                     in_u_flow,
  input  logic                     in_o_flow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_y,
  output logic                     out_u_flow,
  output logic                     out_o_flow,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     sticky_u,
  output logic                     sticky_o,
  input  logic                     clr_sticky
`ifdef FPMUL_FLAG_COUNT_EN
  ,
  output logic [CNT_W-1:0]         uflow_cnt,
  output logic [CNT_W-1:0]         oflow_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [31:0]   mem_y [DEPTH];
  logic          mem_u [DEPTH];
  logic          mem_o [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   fix_y;
  logic          push;
  logic          pop;
  logic          set_u;
  logic          set_o;

  assign in_ready  = (level != FULL_LVL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign set_u     = push && in_u_flow;
  assign set_o     = push && in_o_flow;

  assign out_y      = mem_y[rd_ptr];
  assign out_u_flow = mem_u[rd_ptr];
  assign out_o_flow = mem_o[rd_ptr];

  // Overflow takes precedence over underflow when both flags arrive together.
  always_comb begin
    fix_y = in_y;
    if (in_o_flow)
      fix_y = {in_y[31], 8'hFF, 23'h0};
    else if (in_u_flow)
      fix_y = {in_y[31], 31'h0};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_y[wr_ptr] <= fix_y;
      mem_u[wr_ptr] <= in_u_flow;
      mem_o[wr_ptr] <= in_o_flow;
    end
  end

  // Pointer width equals log2(DEPTH), so natural rollover is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A flagged push in the same cycle as clr_sticky leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_u <= 1'b0;
      sticky_o <= 1'b0;
    end else if (clr_sticky) begin
      sticky_u <= set_u;
      sticky_o <= set_o;
    end else begin
      if (set_u) sticky_u <= 1'b1;
      if (set_o) sticky_o <= 1'b1;
    end
  end

`ifdef FPMUL_FLAG_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      uflow_cnt <= '0;
      oflow_cnt <= '0;
    end else if (clr_sticky) begin
      uflow_cnt <= {{(CNT_W-1){1'b0}}, set_u};
      oflow_cnt <= {{(CNT_W-1){1'b0}}, set_o};
    end else begin
      if (set_u && (uflow_cnt != '1)) uflow_cnt <= uflow_cnt + 1'b1;
      if (set_o && (oflow_cnt != '1)) oflow_cnt <= oflow_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fpmul_result_fifo.sv
// Self-checking bench for fpmul_result_fifo against a queue-based reference model.
// Counter checks are compiled in when FPMUL_FLAG_COUNT_EN is defined.
module tb_fpmul_result_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] y;
    logic        u;
    logic        o;
  } entry_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_y;
  logic          in_u_flow;
  logic          in_o_flow;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_y;
  logic          out_u_flow;
  logic          out_o_flow;
  logic [LW-1:0] level;
  logic          sticky_u;
  logic          sticky_o;
  logic          clr_sticky;
`ifdef FPMUL_FLAG_COUNT_EN
  logic [CNT_W-1:0] uflow_cnt;
  logic [CNT_W-1:0] oflow_cnt;
`endif

  int errors = 0;
  int checks = 0;

  entry_t mq[$];
  logic   m_su, m_so;
  int     m_cu, m_co;

  fpmul_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
    .in_u_flow(in_u_flow), .in_o_flow(in_o_flow),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_u_flow(out_u_flow), .out_o_flow(out_o_flow),
    .level(level), .sticky_u(sticky_u), .sticky_o(sticky_o),
    .clr_sticky(clr_sticky)
`ifdef FPMUL_FLAG_COUNT_EN
    , .uflow_cnt(uflow_cnt), .oflow_cnt(oflow_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] expect_y(logic [31:0] y, logic u, logic o);
    if (o)      return {y[31], 8'hFF, 23'h0};
    else if (u) return {y[31], 31'h0};
    else        return y;
  endfunction

  // One clock: model decides push/pop from its own occupancy, then advances.
  task automatic cycle();
    bit push, pop;
    entry_t e;
    int maxc;
    maxc = (1 << CNT_W) - 1;
    push = in_valid && (mq.size() != DEPTH);
    pop  = out_ready && (mq.size() != 0);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_su = 0; m_so = 0; m_cu = 0; m_co = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.y = expect_y(in_y, in_u_flow, in_o_flow);
        e.u = in_u_flow;
        e.o = in_o_flow;
        mq.push_back(e);
      end
      if (clr_sticky) begin
        m_su = push && in_u_flow;
        m_so = push && in_o_flow;
        m_cu = (push && in_u_flow) ? 1 : 0;
        m_co = (push && in_o_flow) ? 1 : 0;
      end else begin
        if (push && in_u_flow) begin m_su = 1; if (m_cu < maxc) m_cu++; end
        if (push && in_o_flow) begin m_so = 1; if (m_co < maxc) m_co++; end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; in_y = '0; in_u_flow = 0; in_o_flow = 0;
    clr_sticky = 0; rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cycle(); cycle();
    rst = 0;
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({sticky_u, sticky_o} !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b%b exp 00", sticky_u, sticky_o); end
  endtask

  task automatic test_pass_through();
    idle_inputs();
    in_valid = 1; in_y = 32'h3F800000;
    cycle();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_out_valid got %b exp 1", out_valid); end
    checks++; if (out_y !== 32'h3F800000) begin errors++; $display("FAIL pass_out_y got %h exp 3f800000", out_y); end
    out_ready = 1;
    cycle();
    out_ready = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_fixup();
    idle_inputs();
    in_valid = 1; in_y = 32'h80123456; in_u_flow = 1;
    cycle();
    in_valid = 0; in_u_flow = 0;
    checks++; if (out_y !== 32'h80000000) begin errors++; $display("FAIL fix_zero_y got %h exp 80000000", out_y); end
    checks++; if (out_u_flow !== 1'b1) begin errors++; $display("FAIL fix_zero_flag got %b exp 1", out_u_flow); end
    checks++; if (sticky_u !== 1'b1) begin errors++; $display("FAIL fix_sticky_u got %b exp 1", sticky_u); end
    out_ready = 1; cycle(); out_ready = 0;
    in_valid = 1; in_y = 32'h7F000001; in_o_flow = 1;
    cycle();
    in_valid = 0; in_o_flow = 0;
    checks++; if (out_y !== 32'h7F800000) begin errors++; $display("FAIL fix_inf_y got %h exp 7f800000", out_y); end
    checks++; if (sticky_o !== 1'b1) begin errors++; $display("FAIL fix_sticky_o got %b exp 1", sticky_o); end
    out_ready = 1; cycle(); out_ready = 0;
  endtask

  task automatic test_full();
    logic [31:0] v [5];
    v[0] = 32'h11111111; v[1] = 32'h22222222; v[2] = 32'h33333333;
    v[3] = 32'h44444444; v[4] = 32'h55555555;
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_y = v[i];
      checks++; if (in_ready !== (i < 4)) begin errors++; $display("FAIL full_in_ready[%0d] got %b exp %b", i, in_ready, (i < 4)); end
      cycle();
    end
    in_valid = 0;
    checks++; if (level !== LW'(4)) begin errors++; $display("FAIL full_level got %0d exp 4", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_after got %b exp 0", in_ready); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_y !== v[i]) begin errors++; $display("FAIL full_drain[%0d] got %h exp %h", i, out_y, v[i]); end
      cycle();
    end
    out_ready = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_full_with_pop();
    logic [31:0] w [5];
    for (int i = 0; i < 5; i++) w[i] = 32'hA0000000 + i;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin in_valid = 1; in_y = w[i]; cycle(); end
    in_y = w[4]; out_ready = 1;
    cycle();
    checks++; if (level !== LW'(3)) begin errors++; $display("FAIL fwp_level1 got %0d exp 3", level); end
    checks++; if (out_y !== w[1]) begin errors++; $display("FAIL fwp_head1 got %h exp %h", out_y, w[1]); end
    cycle();
    in_valid = 0;
    checks++; if (level !== LW'(3)) begin errors++; $display("FAIL fwp_level2 got %0d exp 3", level); end
    for (int i = 2; i < 5; i++) begin
      checks++; if (out_y !== w[i]) begin errors++; $display("FAIL fwp_drain[%0d] got %h exp %h", i, out_y, w[i]); end
      cycle();
    end
    out_ready = 0;
  endtask

  task automatic test_clr_and_counters();
    idle_inputs();
    clr_sticky = 1; cycle(); clr_sticky = 0;
    in_valid = 1; out_ready = 1; in_o_flow = 1;
    for (int i = 0; i < 300; i++) begin in_y = $urandom; cycle(); end
`ifdef FPMUL_FLAG_COUNT_EN
    checks++; if (oflow_cnt !== 8'd255) begin errors++; $display("FAIL cnt_sat got %0d exp 255", oflow_cnt); end
    checks++; if (uflow_cnt !== 8'd0) begin errors++; $display("FAIL cnt_u_idle got %0d exp 0", uflow_cnt); end
`endif
    clr_sticky = 1; in_u_flow = 0;
    cycle();
    clr_sticky = 0; in_valid = 0; in_o_flow = 0;
    checks++; if (sticky_o !== 1'b1) begin errors++; $display("FAIL clr_set_sticky_o got %b exp 1", sticky_o); end
    checks++; if (sticky_u !== 1'b0) begin errors++; $display("FAIL clr_sticky_u got %b exp 0", sticky_u); end
`ifdef FPMUL_FLAG_COUNT_EN
    checks++; if (oflow_cnt !== 8'd1) begin errors++; $display("FAIL clr_set_cnt got %0d exp 1", oflow_cnt); end
`endif
    cycle(); cycle();
    out_ready = 0;
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_y = 32'hC0000000 + i; in_u_flow = (i == 1); cycle();
    end
    in_u_flow = 0;
    checks++; if (level !== LW'(3)) begin errors++; $display("FAIL rmid_pre_level got %0d exp 3", level); end
    in_o_flow = 1; rst = 1;
    cycle();
    rst = 0; in_valid = 0; in_o_flow = 0;
    checks++; if (level !== '0) begin errors++; $display("FAIL rmid_level got %0d exp 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
    checks++; if ({sticky_u, sticky_o} !== 2'b00) begin errors++; $display("FAIL rmid_sticky got %b%b exp 00", sticky_u, sticky_o); end
  endtask

  task automatic test_random();
    logic [LW-1:0] exp_lvl;
    idle_inputs();
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_y       = $urandom;
      in_u_flow  = ($urandom_range(0, 5) == 0);
      in_o_flow  = ($urandom_range(0, 5) == 0);
      clr_sticky = ($urandom_range(0, 30) == 0);
      rst        = ($urandom_range(0, 80) == 0);
      cycle();
      exp_lvl = LW'(mq.size());
      checks++; if (level !== exp_lvl) begin errors++; $display("FAIL rnd_level@%0d got %0d exp %0d", i, level, exp_lvl); end
      checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_out_valid@%0d got %b", i, out_valid); end
      checks++; if (in_ready !== (mq.size() != DEPTH)) begin errors++; $display("FAIL rnd_in_ready@%0d got %b", i, in_ready); end
      if (mq.size() != 0) begin
        checks++;
        if ({out_y, out_u_flow, out_o_flow} !== {mq[0].y, mq[0].u, mq[0].o}) begin
          errors++; $display("FAIL rnd_head@%0d got %h/%b%b exp %h/%b%b", i, out_y, out_u_flow, out_o_flow, mq[0].y, mq[0].u, mq[0].o);
        end
      end
      checks++; if ({sticky_u, sticky_o} !== {m_su, m_so}) begin errors++; $display("FAIL rnd_sticky@%0d got %b%b exp %b%b", i, sticky_u, sticky_o, m_su, m_so); end
`ifdef FPMUL_FLAG_COUNT_EN
      checks++; if ({uflow_cnt, oflow_cnt} !== {CNT_W'(m_cu), CNT_W'(m_co)}) begin errors++; $display("FAIL rnd_cnt@%0d got %0d/%0d exp %0d/%0d", i, uflow_cnt, oflow_cnt, m_cu, m_co); end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    m_su = 0; m_so = 0; m_cu = 0; m_co = 0;
    idle_inputs();
    test_reset();
    test_pass_through();
    test_fixup();
    test_full();
    test_full_with_pop();
    test_clr_and_counters();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
